// File: rtl/call_ret_sequencer.sv
// Initiator-side sequencer for a hardware return-address stack: turns CALL/RET
// requests into single push/pop strobes and hands the resolved PC to fetch.
module call_ret_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [ADDR_W-1:0] call_target,
  output logic              busy,
  output logic              done,
  output logic              pc_load,
  output logic [ADDR_W-1:0] next_pc,
  output logic              err_ovf,
  output logic              err_unf,
  output logic [CNT_W-1:0]  depth,
  output logic              stk_write_en,
  output logic              stk_read_en,
  output logic [ADDR_W-1:0] stk_data_in,
  input  logic [ADDR_W-1:0] stk_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POP_WAIT,
    S_FINISH,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t            state_q;
  logic [CNT_W-1:0]  depth_q;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] next_pc_q;
  logic [ADDR_W-1:0] data_in_q;
  logic              done_q;
  logic              pc_load_q;
  logic              err_ovf_q;
  logic              err_unf_q;
  logic              wr_q;
  logic              rd_q;

  // Every output is a register; strobes and pulses are set on entry to the
  // state in which they must be visible, and cleared by default afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      depth_q   <= '0;
      target_q  <= '0;
      next_pc_q <= '0;
      data_in_q <= '0;
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      data_in_q <= '0;
      case (state_q)
        S_IDLE: begin
          // CALL has priority; a simultaneous RET is simply dropped.
          if (call_req) begin
            if (depth_q == FULL) begin
              state_q   <= S_ERR;
              done_q    <= 1'b1;
              err_ovf_q <= 1'b1;
            end else begin
              state_q   <= S_PUSH;
              target_q  <= call_target;
              data_in_q <= pc_plus1;
              wr_q      <= 1'b1;
            end
          end else if (ret_req) begin
            if (depth_q == '0) begin
              state_q   <= S_ERR;
              done_q    <= 1'b1;
              err_unf_q <= 1'b1;
            end else begin
              state_q <= S_POP;
              rd_q    <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          depth_q   <= depth_q + 1'b1;
          next_pc_q <= target_q;
          done_q    <= 1'b1;
          pc_load_q <= 1'b1;
          state_q   <= S_FINISH;
        end
        S_POP: begin
          depth_q <= depth_q - 1'b1;
          state_q <= S_POP_WAIT;
        end
        S_POP_WAIT: begin
          // Stack data_out is registered, so it is valid one cycle after the read strobe.
          next_pc_q <= stk_data_out;
          done_q    <= 1'b1;
          pc_load_q <= 1'b1;
          state_q   <= S_FINISH;
        end
        S_FINISH: state_q <= S_IDLE;
        S_ERR:    state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign pc_load      = pc_load_q;
  assign next_pc      = next_pc_q;
  assign err_ovf      = err_ovf_q;
  assign err_unf      = err_unf_q;
  assign depth        = depth_q;
  assign stk_write_en = wr_q;
  assign stk_read_en  = rd_q;
  assign stk_data_in  = data_in_q;

endmodule

// File: doc/call_ret_sequencer.md
Name: call_ret_sequencer

Overview:
Initiator-side controller for the hardware return-address stack in the processor datapath. It accepts CALL/RET requests from the control unit and sequences push/pop operations on the stack's write_en/read_en/data_in/data_out interface. It returns the resolved next PC to the fetch stage. It mirrors the stack pointer internally so that overflow and underflow are caught before the stack is touched.

Parameters:
DEPTH, 16, capacity of the attached stack in entries; must match the stack instance
ADDR_W, 32, PC / return-address width; the stack data width equals ADDR_W
CNT_W, 5, width of the occupancy counter; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
call_req  input  1  one-cycle CALL request; sampled only in IDLE
ret_req  input  1  one-cycle RET request; sampled only in IDLE
pc_plus1  input  ADDR_W  return address to push; captured with call_req
call_target  input  ADDR_W  branch target; captured with call_req
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when an operation completes, including error completion
pc_load  output  1  one-cycle pulse, coincident with done, when next_pc is valid
next_pc  output  ADDR_W  resolved PC: call target or popped return address
err_ovf  output  1  one-cycle pulse: CALL issued with a full stack
err_unf  output  1  one-cycle pulse: RET issued with an empty stack
depth  output  CNT_W  current stack occupancy
stk_write_en  output  1  drives the stack's write_en
stk_read_en  output  1  drives the stack's read_en
stk_data_in  output  ADDR_W  drives the stack's data_in
stk_data_out  input  ADDR_W  stack's registered data_out; valid the cycle after stk_read_en

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, depth 0, all outputs 0, capture registers 0. Reset asserted mid-operation aborts the operation immediately. No done is produced and no further stack strobe is issued.
- FSM states: IDLE, PUSH, POP, POP_WAIT, FINISH, ERR.
- IDLE:
  - call_req=1 and depth<DEPTH: capture pc_plus1 and call_target, go to PUSH.
  - call_req=1 and depth==DEPTH: go to ERR with the overflow flag set.
  - ret_req=1 and depth>0: go to POP.
  - ret_req=1 and depth==0: go to ERR with the underflow flag set.
  - call_req and ret_req both high: CALL wins and RET is dropped. The requester must re-issue the RET.
- PUSH:
  - stk_write_en=1 for exactly one cycle; stk_data_in = captured pc_plus1.
  - depth increments at the end of the cycle.
  - next_pc is loaded with the captured call_target. Go to FINISH.
- POP:
  - stk_read_en=1 for exactly one cycle.
  - depth decrements at the end of the cycle. Go to POP_WAIT.
- POP_WAIT: register stk_data_out into next_pc at the end of the cycle. Go to FINISH.
- FINISH: done=1 and pc_load=1 for one cycle. Go to IDLE.
- ERR:
  - done=1, pc_load=0, and err_ovf or err_unf =1, all for one cycle.
  - No stack strobe is issued and depth is unchanged. next_pc holds its previous value. Go to IDLE.
- Latency, with the request sampled at edge N:
  - CALL: stk_write_en high in cycle N+1; done/pc_load high in cycle N+2.
  - RET: stk_read_en high in cycle N+1; done/pc_load high in cycle N+3.
  - Error: done high in cycle N+1.
- stk_write_en and stk_read_en are never high in the same cycle. Neither is high outside PUSH/POP.
- Requests arriving while busy=1 are ignored and not queued. The requester holds off while busy is high.
- depth is always in the range 0..DEPTH and never wraps. stk_data_in is 0 whenever stk_write_en is 0.
- The sequencer owns the stack exclusively; no other agent may strobe it.
- Back-to-back: a new request may be sampled in the cycle after done (the IDLE cycle). Minimum spacing is 3 cycles for CALL and 4 cycles for RET.

Test Plan:
- Reset then CALL (pc_plus1=0x104, call_target=0x400):
  - stk_write_en=1 with stk_data_in=0x104 at N+1.
  - done=pc_load=1 with next_pc=0x400 at N+2; depth=1.
- Follow with RET:
  - stk_read_en=1 at N+1.
  - done=pc_load=1 with next_pc=0x104 at N+3; depth=0.
- Nested: 3 CALLs with pc_plus1=0x10, 0x20, 0x30, then 3 RETs:
  - RET next_pc sequence is 0x30, 0x20, 0x10; depth goes 3→0.
- 16 CALLs then a 17th CALL:
  - 17th gives err_ovf=1 and done=1 with pc_load=0 at N+1.
  - No stk_write_en; depth stays 16.
- RET from reset (depth=0): err_unf=1, done=1 at N+1; no stk_read_en; depth stays 0.
- call_req and ret_req high together in IDLE: a CALL is performed. Then pulse ret_req while busy=1: it is ignored and depth is unchanged by it. Finally, drop rst_n during POP_WAIT:
  - all outputs read 0 immediately and depth=0.
  - no done pulse follows.
